// File: rtl/aemb_intc_if.sv
// Wishbone slave bus bundle for the AEMB interrupt controller.
// Signal names keep their original port spelling so existing bus wiring maps one-to-one.
interface aemb_intc_if;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/aemb_intc.sv
// Interrupt controller for the AEMB core: latches up to 32 sources and
// guarantees a fresh low-to-high edge on sys_int_o for every new request.
module aemb_intc #(
    parameter int          NSRC = 8,
    parameter logic [31:0] EDGE = 32'h0,
    parameter int          GAP  = 2
) (
    input  logic            nclk,
    input  logic            sys_rst_i,
    aemb_intc_if.slave      wb,
    input  logic [NSRC-1:0] irq_i,
    output logic            sys_int_o
);

    localparam int              CW     = $clog2(GAP + 1);
    localparam logic [NSRC-1:0] EDGE_M = EDGE[NSRC-1:0];

    typedef enum logic [1:0] {IDLE, ASSERT, HOLD} state_t;

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] isr, ier;
    logic [NSRC-1:0] set_v, clr_v;
    logic            mer;
    logic            stb_new, wr, ctl_wr_q, active;
    logic [31:0]     rdata;
    logic            unused_dat;
    state_t          state;
    logic [CW-1:0]   cnt;

    assign stb_new    = wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr         = stb_new & wb.wb_we_i;
    assign set_v      = (EDGE_M & s2 & ~s3) | (~EDGE_M & s2);
    assign active     = mer & (|(isr & ier));
    assign unused_dat = ^wb.wb_dat_i;

    always_comb begin
        clr_v = '0;
        if (wr && wb.wb_adr_i == 2'd0)
            clr_v = wb.wb_dat_i[NSRC-1:0];
    end

    always_comb begin
        rdata = '0;
        case (wb.wb_adr_i)
            2'd0:    rdata = 32'(isr);
            2'd1:    rdata = 32'(ier);
            2'd2:    rdata = 32'(isr & ier);
            default: rdata = {31'b0, mer};
        endcase
    end

    always_ff @(posedge nclk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge nclk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            isr      <= '0;
            ier      <= '0;
            mer      <= 1'b0;
            ctl_wr_q <= 1'b0;
        end else begin
            isr      <= (isr & ~clr_v) | set_v;
            ctl_wr_q <= wr & (wb.wb_adr_i != 2'd2);
            if (wr && wb.wb_adr_i == 2'd1)
                ier <= wb.wb_dat_i[NSRC-1:0];
            if (wr && wb.wb_adr_i == 2'd3)
                mer <= wb.wb_dat_i[0];
        end
    end

    always_ff @(posedge nclk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            wb.wb_ack_o <= stb_new;
            wb.wb_dat_o <= stb_new ? rdata : '0;
        end
    end

    // Control writes are registered so that a software acknowledge and a
    // pending-set drop both leave ASSERT one edge after the committing ack.
    always_ff @(posedge nclk or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            sys_int_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        state     <= ASSERT;
                        sys_int_o <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (!active || ctl_wr_q) begin
                        state     <= HOLD;
                        sys_int_o <= 1'b0;
                        cnt       <= CW'(GAP);
                    end
                end
                HOLD: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    sys_int_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aemb_intc.sv
// Directed bench for aemb_intc: register access, latency, acknowledge gap,
// level/edge sources, set/clear collision, master disable and async reset.
module tb_aemb_intc;

    localparam int NSRC = 8;
    localparam int GAP  = 2;

    logic            nclk = 1'b0;
    logic            sys_rst_i;
    logic [NSRC-1:0] irq_i;
    logic            sys_int_o;
    logic [31:0]     rd;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    aemb_intc_if bus ();

    aemb_intc #(
        .NSRC (NSRC),
        .EDGE (32'h0000_000B),
        .GAP  (GAP)
    ) dut (
        .nclk      (nclk),
        .sys_rst_i (sys_rst_i),
        .wb        (bus.slave),
        .irq_i     (irq_i),
        .sys_int_o (sys_int_o)
    );

    always #5 nclk = ~nclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                            output logic [31:0] rdat);
        int n;
        @(negedge nclk);
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        n = 0;
        do begin
            @(posedge nclk);
            #1;
            n++;
        end while (bus.wb_ack_o !== 1'b1 && n < 8);
        check("ack_seen", {31'b0, bus.wb_ack_o}, 32'd1);
        rdat = bus.wb_dat_o;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_cycle(1'b1, adr, dat, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] got;
        exp_q.push_back(exp);
        wb_cycle(1'b0, adr, 32'h0, got);
        check(tag, got, exp_q.pop_front());
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge nclk);
            #1;
        end
    endtask

    task automatic chk_int(input string tag, input logic exp);
        exp_q.push_back({31'b0, exp});
        check(tag, {31'b0, sys_int_o}, exp_q.pop_front());
    endtask

    task automatic wait_int(input string tag);
        int n;
        n = 0;
        while (sys_int_o !== 1'b1 && n < 20) begin
            @(posedge nclk);
            #1;
            n++;
        end
        chk_int(tag, 1'b1);
    endtask

    initial begin
        sys_rst_i    = 1'b0;
        irq_i        = '0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 2'd0;
        bus.wb_dat_i = '0;
        cyc(3);
        @(negedge nclk);
        sys_rst_i = 1'b1;
        cyc(1);

        // reset state
        chk_int("rst_int", 1'b0);
        check("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        rd_chk("rst_isr", 2'd0, 32'h0);
        rd_chk("rst_ier", 2'd1, 32'h0);
        rd_chk("rst_ipr", 2'd2, 32'h0);
        rd_chk("rst_mer", 2'd3, 32'h0);
        cyc(1);
        check("dat_idle", bus.wb_dat_o, 32'd0);

        // back-to-back strobe: ack every second cycle
        @(negedge nclk);
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = 2'd1;
        cyc(1);
        check("b2b_ack0", {31'b0, bus.wb_ack_o}, 32'd1);
        cyc(1);
        check("b2b_ack1", {31'b0, bus.wb_ack_o}, 32'd0);
        cyc(1);
        check("b2b_ack2", {31'b0, bus.wb_ack_o}, 32'd1);
        bus.wb_stb_i = 1'b0;
        cyc(2);

        // enables; upper bits ignore writes, IPR ignores writes
        wr(2'd1, 32'hFFFF_FF0F);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFFF);
        rd_chk("ier_rb", 2'd1, 32'h0F);
        rd_chk("mer_rb", 2'd3, 32'h01);
        rd_chk("ipr_ro", 2'd2, 32'h00);
        cyc(4);

        // single-cycle edge pulse on source 0: latency T0..T3
        @(negedge nclk);
        irq_i = 8'h01;
        cyc(1);
        chk_int("lat_t0", 1'b0);
        @(negedge nclk);
        irq_i = 8'h00;
        cyc(1);
        chk_int("lat_t1", 1'b0);
        cyc(1);
        chk_int("lat_t2", 1'b0);
        cyc(1);
        chk_int("lat_t3", 1'b1);
        rd_chk("isr_edge0", 2'd0, 32'h01);
        rd_chk("ipr_edge0", 2'd2, 32'h01);
        chk_int("held_over_reads", 1'b1);

        // acknowledge the only source
        wr(2'd0, 32'h01);
        chk_int("ack_a", 1'b1);
        cyc(1);
        chk_int("ack_a1", 1'b0);
        cyc(6);
        chk_int("ack_stays_low", 1'b0);

        // sources 0 and 3, clear only 0: fresh edge after the gap
        @(negedge nclk);
        irq_i = 8'h09;
        @(negedge nclk);
        irq_i = 8'h00;
        wait_int("two_src_up");
        wr(2'd0, 32'h01);
        cyc(1);
        chk_int("gap_a1", 1'b0);
        cyc(1);
        chk_int("gap_a2", 1'b0);
        cyc(1);
        chk_int("gap_a3", 1'b0);
        cyc(1);
        chk_int("gap_a4_rearm", 1'b1);
        rd_chk("ipr_src3", 2'd2, 32'h08);
        wr(2'd0, 32'h08);
        cyc(6);
        chk_int("src3_cleared", 1'b0);

        // level source 2 stays pending while high
        @(negedge nclk);
        irq_i = 8'h04;
        wait_int("lvl_up");
        rd_chk("lvl_isr", 2'd0, 32'h04);
        wr(2'd0, 32'h04);
        rd_chk("lvl_sticky", 2'd0, 32'h04);
        @(negedge nclk);
        irq_i = 8'h00;
        cyc(4);
        wr(2'd0, 32'h04);
        rd_chk("lvl_clear", 2'd0, 32'h00);
        cyc(6);
        chk_int("lvl_quiet", 1'b0);

        // edge on source 1 coincides with its clear: set wins
        @(negedge nclk);
        irq_i = 8'h02;
        @(negedge nclk);
        irq_i = 8'h00;
        wr(2'd0, 32'h02);
        rd_chk("set_wins", 2'd0, 32'h02);
        wr(2'd0, 32'h02);
        rd_chk("collide_clr", 2'd0, 32'h00);
        cyc(6);

        // master disable while asserted
        @(negedge nclk);
        irq_i = 8'h01;
        @(negedge nclk);
        irq_i = 8'h00;
        wait_int("mer_pre");
        wr(2'd3, 32'h0);
        cyc(1);
        chk_int("mer_off_a1", 1'b0);
        cyc(6);
        chk_int("mer_off_low", 1'b0);
        rd_chk("mer_off_isr", 2'd0, 32'h01);
        rd_chk("mer_off_rb", 2'd3, 32'h00);

        // asynchronous reset in the middle of a bus cycle
        wr(2'd3, 32'h1);
        wait_int("pre_rst_up");
        @(negedge nclk);
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 2'd0;
        #2;
        sys_rst_i = 1'b0;
        #1;
        chk_int("rst_async_int", 1'b0);
        cyc(1);
        check("rst_mid_ack", {31'b0, bus.wb_ack_o}, 32'd0);
        check("rst_mid_dat", bus.wb_dat_o, 32'd0);
        chk_int("rst_mid_int", 1'b0);
        @(negedge nclk);
        bus.wb_stb_i = 1'b0;
        sys_rst_i    = 1'b1;
        rd_chk("post_isr", 2'd0, 32'h0);
        rd_chk("post_ier", 2'd1, 32'h0);
        rd_chk("post_mer", 2'd3, 32'h0);
        cyc(4);
        chk_int("post_int", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
